reset_release_cycle_counter: RTL and testbench



---
 rtl/reset_release_cycle_counter.sv | 76 +++++++
 tb/tb_reset_release_cycle_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_release_cycle_counter.sv
// Delays release_i through a flop chain into a local reset and runs a cycle counter behind it.
// Define RESET_RELEASE_CYCLE_COUNTER_SATURATE_EN to saturate with a sticky flag instead of wrapping.
module reset_release_cycle_counter #(
    parameter int unsigned        width_p      = 32,
    parameter int unsigned        num_stages_p = 3,
    parameter logic [width_p-1:0] init_val_p   = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               release_i,
    output logic               reset_o,
    output logic [width_p-1:0] ctr_r_o,
    output logic               ctr_wrap_o
);

    localparam logic [width_p-1:0] ctr_max_lp = '1;

    generate
        if (num_stages_p == 0) begin : g_comb
            assign reset_o = ~release_i;
        end else begin : g_chain
            logic [num_stages_p-1:0] stage_q, stage_d;

            always_comb begin
                stage_d    = stage_q;
                stage_d[0] = ~release_i;
                for (int i = 1; i < int'(num_stages_p); i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Every stage powers up asserted so reset_o is high throughout reset_i.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) stage_q <= '1;
                else         stage_q <= stage_d;
            end

            assign reset_o = stage_q[num_stages_p-1];
        end
    endgenerate

    logic [width_p-1:0] ctr_q, ctr_d;
    logic               wrap_q, wrap_d;

    // The counter looks at the current reset_o, so it trails the chain by one edge.
    always_comb begin
        ctr_d  = ctr_q;
        wrap_d = 1'b0;
        if (reset_o) begin
            ctr_d  = init_val_p;
            wrap_d = 1'b0;
        end else begin
`ifdef RESET_RELEASE_CYCLE_COUNTER_SATURATE_EN
            if (ctr_q != ctr_max_lp) ctr_d = ctr_q + width_p'(1);
            wrap_d = wrap_q | (ctr_d == ctr_max_lp);
`else
            ctr_d  = ctr_q + width_p'(1);
            wrap_d = (ctr_q == ctr_max_lp);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_q  <= init_val_p;
            wrap_q <= 1'b0;
        end else begin
            ctr_q  <= ctr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ctr_r_o    = ctr_q;
    assign ctr_wrap_o = wrap_q;

endmodule

// File: tb/tb_reset_release_cycle_counter.sv
// Bench for reset_release_cycle_counter: three parameterizations checked against a
// release-history model, plus directed tables for latency, re-reset, wrap and zero-stage cases.
module tb_reset_release_cycle_counter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  rel;
    logic [2:0]  rst_o, wrap_o;
    logic [31:0] ctr_a;
    logic [3:0]  ctr_b;
    logic [7:0]  ctr_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reset_release_cycle_counter #(.width_p(32), .num_stages_p(3), .init_val_p(32'd0)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .release_i(rel[0]),
        .reset_o(rst_o[0]), .ctr_r_o(ctr_a), .ctr_wrap_o(wrap_o[0]));

    reset_release_cycle_counter #(.width_p(4), .num_stages_p(3), .init_val_p(4'd13)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .release_i(rel[1]),
        .reset_o(rst_o[1]), .ctr_r_o(ctr_b), .ctr_wrap_o(wrap_o[1]));

    reset_release_cycle_counter #(.width_p(8), .num_stages_p(0), .init_val_p(8'd5)) dut_c (
        .clk_i(clk), .reset_i(reset_i), .release_i(rel[2]),
        .reset_o(rst_o[2]), .ctr_r_o(ctr_c), .ctr_wrap_o(wrap_o[2]));

    // Reference model: reset_o is the inverted release seen num_stages edges ago;
    // the counter is init plus the number of consecutive edges taken with reset_o low.
    int     s_m    [3] = '{3, 3, 0};
    int     w_m    [3] = '{32, 4, 8};
    longint init_m [3] = '{0, 13, 5};
    bit     rel_log[3][64];
    longint n_m    [3];
    int     e_m;

    function automatic logic model_rst(int d);
        if (s_m[d] == 0) return ~rel[d];
        if (e_m < s_m[d]) return 1'b1;
        return ~rel_log[d][(e_m - s_m[d]) % 64];
    endfunction

    function automatic longint model_ctr(int d);
        longint m = longint'(1) << w_m[d];
        longint v = init_m[d] + n_m[d];
`ifdef RESET_RELEASE_CYCLE_COUNTER_SATURATE_EN
        return (v > m - 1) ? m - 1 : v;
`else
        return v % m;
`endif
    endfunction

    function automatic logic model_wrap(int d);
        longint m = longint'(1) << w_m[d];
        if (n_m[d] == 0) return 1'b0;
`ifdef RESET_RELEASE_CYCLE_COUNTER_SATURATE_EN
        return (init_m[d] + n_m[d]) >= m - 1;
`else
        return ((init_m[d] + n_m[d]) % m) == 0;
`endif
    endfunction

    function automatic logic [63:0] act_ctr(int d);
        case (d)
            0:       return 64'(ctr_a);
            1:       return 64'(ctr_b);
            default: return 64'(ctr_c);
        endcase
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model rst_o[%0d]", d), 64'(rst_o[d]), 64'(model_rst(d)));
            chk($sformatf("model ctr[%0d]", d), act_ctr(d), 64'(model_ctr(d)));
            chk($sformatf("model wrap[%0d]", d), 64'(wrap_o[d]), 64'(model_wrap(d)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_i) begin
            for (int d = 0; d < 3; d++) begin
                if (model_rst(d)) n_m[d] = 0;
                else              n_m[d]++;
                rel_log[d][e_m % 64] = rel[d];
            end
            e_m++;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        reset_i = 1'b1;
        #1;
        e_m = 0;
        for (int d = 0; d < 3; d++) n_m[d] = 0;
        chk("async rst_o a", 64'(rst_o[0]), 64'd1);
        chk("async rst_o b", 64'(rst_o[1]), 64'd1);
        chk("async rst_o c", 64'(rst_o[2]), 64'(model_rst(2)));
        chk("async ctr a", 64'(ctr_a), 64'd0);
        chk("async ctr b", 64'(ctr_b), 64'd13);
        chk("async ctr c", 64'(ctr_c), 64'd5);
        chk("async wrap", 64'(wrap_o), 64'd0);
        step();
        step();
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    typedef struct {
        logic        rel;
        logic        exp_rst;
        logic [31:0] exp_ctr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int ctr_seq [4];
        int wrap_seq[4];

        tbl[0]  = '{1'b0, 1'b1, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'd1};
        tbl[5]  = '{1'b1, 1'b0, 32'd2};
        tbl[6]  = '{1'b0, 1'b0, 32'd3};
        tbl[7]  = '{1'b0, 1'b0, 32'd4};
        tbl[8]  = '{1'b0, 1'b1, 32'd5};
        tbl[9]  = '{1'b0, 1'b1, 32'd0};
        tbl[10] = '{1'b0, 1'b1, 32'd0};
`ifdef RESET_RELEASE_CYCLE_COUNTER_SATURATE_EN
        ctr_seq  = '{14, 15, 15, 15};
        wrap_seq = '{0, 1, 1, 1};
`else
        ctr_seq  = '{14, 15, 0, 1};
        wrap_seq = '{0, 0, 1, 0};
`endif

        reset_i = 1'b0;
        rel     = 3'b111;
        e_m     = 0;
        for (int d = 0; d < 3; d++) n_m[d] = 0;
        #1;
        do_reset();

        // Release latency and reassert on dut_a.
        rel = 3'b000;
        for (int k = 0; k < 11; k++) begin
            rel[0] = tbl[k].rel;
            step();
            chk($sformatf("tbl%0d rst_o", k), 64'(rst_o[0]), 64'(tbl[k].exp_rst));
            chk($sformatf("tbl%0d ctr", k), 64'(ctr_a), 64'(tbl[k].exp_ctr));
            chk($sformatf("tbl%0d wrap", k), 64'(wrap_o[0]), 64'd0);
        end

        // Re-reset mid-count at 57.
        rel[0] = 1'b1;
        for (int k = 0; k < 300 && ctr_a != 32'd57; k++) step();
        chk("reach 57", 64'(ctr_a), 64'd57);
        rel[0] = 1'b0;
        step(); chk("rr rst0", 64'(rst_o[0]), 64'd0); chk("rr ctr58", 64'(ctr_a), 64'd58);
        step(); chk("rr rst1", 64'(rst_o[0]), 64'd0); chk("rr ctr59", 64'(ctr_a), 64'd59);
        step(); chk("rr rst2", 64'(rst_o[0]), 64'd1); chk("rr ctr60", 64'(ctr_a), 64'd60);
        step(); chk("rr reload", 64'(ctr_a), 64'd0);

        // Zero-stage chain is combinational.
        rel[2] = 1'b1;
        #1;
        chk("s0 comb low", 64'(rst_o[2]), 64'd0);
        rel[2] = 1'b0;
        #1;
        chk("s0 comb high", 64'(rst_o[2]), 64'd1);
        step(); chk("s0 reload", 64'(ctr_c), 64'd5);
        rel[2] = 1'b1;
        step(); chk("s0 count", 64'(ctr_c), 64'd6);

        // Wrap (or saturate) on the 4-bit counter starting at 13.
        rel = 3'b000;
        do_reset();
        rel[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 2) chk("wb rst still high", 64'(rst_o[1]), 64'd1);
            if (k == 3) chk("wb rst low", 64'(rst_o[1]), 64'd0);
            if (k >= 4) begin
                chk($sformatf("wb ctr e%0d", k), 64'(ctr_b), 64'(ctr_seq[k-4]));
                chk($sformatf("wb wrap e%0d", k), 64'(wrap_o[1]), 64'(wrap_seq[k-4]));
            end
        end
        rel[1] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("wb wrap cleared", 64'(wrap_o[1]), 64'd0);
        chk("wb ctr reloaded", 64'(ctr_b), 64'd13);

        // Random release activity with occasional async resets.
        rel = 3'b111;
        for (int k = 0; k < 600; k++) begin
            for (int d = 0; d < 3; d++)
                if ($urandom_range(0, 19) == 0) rel[d] = ~rel[d];
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
